// File: rtl/hs_buffer.sv
// hs_buffer: valid/ready elastic buffer of DEPTH entries of WIDTH bits.
// Words are delivered in push order with a 1-cycle latency and no bypass.
// ready_o and valid_o are decoded only from the registered occupancy.
// Optional feature: define HS_BUFFER_COUNT_EN to add the count_o occupancy port.
module hs_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
`ifdef HS_BUFFER_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake decode and next-state for pointers and occupancy.
    always_comb begin
        ready_o  = (count_q != CNT_FULL);
        valid_o  = (count_q != '0);
        push     = valid_i && ready_o;
        pop      = valid_o && ready_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are not reset, the data_o mask hides stale entries.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef HS_BUFFER_COUNT_EN
    assign count_o = count_q;
`endif

endmodule

// File: doc/hs_buffer.md
HS_BUFFER -- requirements
Module: hs_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (minimum 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the buffer entry count (power of two, minimum 2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port valid_i  input  1  master presents data.
REQ-006 The block SHALL have port ready_o  output  1  block can accept from master.
REQ-007 The block SHALL have port data_i  input  WIDTH  payload from master.
REQ-008 The block SHALL have port valid_o  output  1  data available to slave.
REQ-009 The block SHALL have port ready_i  input  1  slave accepts.
REQ-010 The block SHALL have port data_o  output  WIDTH  payload to slave.
REQ-011 The block SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy, present only when HS_BUFFER_COUNT_EN is defined.

Function
REQ-012 A push SHALL occur on a rising clk edge where valid_i and ready_o are both 1; data_i is written at the write pointer.
REQ-013 A pop SHALL occur on a rising clk edge where valid_o and ready_i are both 1; the read pointer advances.
REQ-014 Occupancy SHALL change as follows: +1 on push only, -1 on pop only, and no change on simultaneous push and pop.
REQ-015 ready_o SHALL equal (occupancy != DEPTH), decoded from registered state only, with no combinational path from ready_i or valid_i.
REQ-016 valid_o SHALL equal (occupancy != 0), decoded from registered state only, with no combinational path from valid_i.
REQ-017 data_o SHALL equal the entry at the read pointer when valid_o=1, and SHALL be all-zero when valid_o=0.
REQ-018 Latency SHALL be 1 cycle: a word pushed into an empty buffer at edge N appears with valid_o=1 after edge N.
REQ-019 Throughput SHALL be 1 word per cycle sustained whenever valid_i=1 and ready_i=1 and occupancy is neither 0 nor DEPTH.
REQ-020 When full, a push SHALL NOT occur even if ready_i=1 in the same cycle; ready_o reasserts the cycle after the pop.
REQ-021 When empty, valid_i SHALL NOT propagate to valid_o in the same cycle (no bypass).
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH from DEPTH-1 to 0.
REQ-023 Words SHALL be delivered in strict push order with no loss or duplication.
REQ-024 While valid_o=1 and ready_i=0, data_o and valid_o SHALL be held stable.
REQ-025 valid_i deasserting without a handshake SHALL NOT alter state.

Reset
REQ-026 While rstn=0 at a rising clk edge, the block SHALL clear the pointers and occupancy to 0; outputs then read valid_o=0, ready_o=1, data_o=0, count_o=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; the first push after reset release is the first word delivered.
REQ-028 Storage array contents SHALL NOT be reset; data_o masking (REQ-017) hides stale contents.

Configuration
REQ-029 The block SHALL use the macro HS_BUFFER_COUNT_EN to compile in or out the occupancy feature.
REQ-030 With HS_BUFFER_COUNT_EN defined, the port count_o SHALL exist and present the registered occupancy value, 0..DEPTH.
REQ-031 Without HS_BUFFER_COUNT_EN, count_o SHALL be absent; all other behaviour is identical.

Verification
REQ-032 The bench SHALL cover reset then idle: outputs 0 except ready_o=1; count_o=0.
REQ-033 The bench SHALL cover the fill case: DEPTH=4, ready_i=0, push 0xA0..0xA3 -> ready_o=0 after the 4th push; a 5th valid_i word 0xA4 is not accepted; count_o=4.
REQ-034 The bench SHALL cover the drain case: from full, ready_i=1, valid_i=0 -> data_o sequence 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then valid_o=0 and data_o=0.
REQ-035 The bench SHALL cover streaming: valid_i=1 and ready_i=1 for 10 cycles with an incrementing payload from 1 -> output 1..10 in order, 1-cycle lag, count_o steady at 1.
REQ-036 The bench SHALL cover wrap plus simultaneous operation: at occupancy 3 with the pointers near DEPTH-1, push and pop in the same cycle -> count unchanged and order preserved across the wrap.
REQ-037 The bench SHALL cover mid-operation reset: rstn=0 for 1 cycle with occupancy 2 -> valid_o=0 next cycle; the next word pushed, 0x55, is the first word output.
